// File: rtl/mario_sprite_seq_ctrl.sv
// Big-Mario sprite controller: walk-animation FSM, mirrored ROM address generation
// and a two-stage transparency-qualified colour pipeline.
module mario_sprite_seq_ctrl #(
    parameter int          SPR_W        = 16,
    parameter int          SPR_H        = 32,
    parameter int          ANIM_DIV     = 6,
    parameter logic [11:0] TRANSP_COLOR = 12'h808
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic        walking,
    input  logic        airborne,
    input  logic        facing_left,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  mario_x,
    input  logic [9:0]  mario_y,
    input  logic [11:0] rom_color,
    output logic [9:0]  read_address,
    output logic [2:0]  frame_sel,
    output logic [11:0] pixel_color,
    output logic        pixel_on
);

    typedef enum logic [2:0] {
        ST_STAND = 3'd0,
        ST_WALK1 = 3'd1,
        ST_WALK2 = 3'd2,
        ST_WALK3 = 3'd3,
        ST_JUMP  = 3'd4
    } state_t;

    localparam logic [5:0]        ANIM_LAST = 6'(ANIM_DIV - 1);
    localparam logic signed [10:0] SPR_W_S  = 11'(SPR_W);
    localparam logic signed [10:0] SPR_H_S  = 11'(SPR_H);
    localparam logic [9:0]        SPR_W_A   = 10'(SPR_W);

    state_t      state_q, state_d;
    logic [5:0]  anim_cnt_q, anim_cnt_d;
    logic [2:0]  frame_sel_q, frame_sel_d;
    logic [9:0]  read_address_q, read_address_d;
    logic        hit_q, hit_d;
    logic [11:0] pixel_color_q, pixel_color_d;
    logic        pixel_on_q, pixel_on_d;

    logic signed [10:0] dx, dy;
    logic [9:0]         xm;

    function automatic state_t next_walk(input state_t cur);
        state_t nxt;
        case (cur)
            ST_WALK1: nxt = ST_WALK2;
            ST_WALK2: nxt = ST_WALK3;
            ST_WALK3: nxt = ST_WALK1;
            default:  nxt = ST_WALK1;
        endcase
        return nxt;
    endfunction

    // Animation state and step counter
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_STAND;
            anim_cnt_q <= 6'd0;
        end else begin
            state_q    <= state_d;
            anim_cnt_q <= anim_cnt_d;
        end
    end

    // Next animation state; only evaluated on vblank ticks so the image never changes mid-frame
    always_comb begin
        state_d    = state_q;
        anim_cnt_d = anim_cnt_q;
        if (frame_tick) begin
            case (state_q)
                ST_STAND: begin
                    if (airborne) begin
                        state_d = ST_JUMP;
                    end else if (walking) begin
                        state_d    = ST_WALK1;
                        anim_cnt_d = 6'd0;
                    end else begin
                        state_d = ST_STAND;
                    end
                end
                ST_WALK1, ST_WALK2, ST_WALK3: begin
                    if (airborne) begin
                        state_d = ST_JUMP;
                    end else if (!walking) begin
                        state_d = ST_STAND;
                    end else if (anim_cnt_q == ANIM_LAST) begin
                        state_d    = next_walk(state_q);
                        anim_cnt_d = 6'd0;
                    end else begin
                        anim_cnt_d = anim_cnt_q + 6'd1;
                    end
                end
                ST_JUMP: begin
                    if (!airborne) begin
                        state_d    = walking ? ST_WALK1 : ST_STAND;
                        anim_cnt_d = 6'd0;
                    end else begin
                        state_d = ST_JUMP;
                    end
                end
                default: begin
                    state_d    = ST_STAND;
                    anim_cnt_d = 6'd0;
                end
            endcase
        end else begin
            state_d    = state_q;
            anim_cnt_d = anim_cnt_q;
        end
    end

    // ROM image select derived from the state
    always_comb begin
        frame_sel_d = 3'd0;
        case (state_q)
            ST_STAND: frame_sel_d = 3'd0;
            ST_WALK1: frame_sel_d = 3'd1;
            ST_WALK2: frame_sel_d = 3'd2;
            ST_WALK3: frame_sel_d = 3'd3;
            ST_JUMP:  frame_sel_d = 3'd4;
            default:  frame_sel_d = 3'd0;
        endcase
    end

    // Offsets are taken at 11 bits signed so a scan left of/above the sprite cannot alias into range
    always_comb begin
        dx    = signed'({1'b0, DrawX}) - signed'({1'b0, mario_x});
        dy    = signed'({1'b0, DrawY}) - signed'({1'b0, mario_y});
        hit_d = !dx[10] && (dx < SPR_W_S) && !dy[10] && (dy < SPR_H_S);
        if (facing_left) begin
            xm = SPR_W_A - 10'd1 - dx[9:0];
        end else begin
            xm = dx[9:0];
        end
        if (hit_d) begin
            read_address_d = dy[9:0] * SPR_W_A + xm;
        end else begin
            read_address_d = 10'd0;
        end
    end

    // Colour stage: rom_color answers the address registered in the previous cycle
    always_comb begin
        if (hit_q) begin
            pixel_color_d = rom_color;
            pixel_on_d    = (rom_color != TRANSP_COLOR);
        end else begin
            pixel_color_d = 12'd0;
            pixel_on_d    = 1'b0;
        end
    end

    // Frame select and pixel pipeline registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_sel_q    <= 3'd0;
            read_address_q <= 10'd0;
            hit_q          <= 1'b0;
            pixel_color_q  <= 12'd0;
            pixel_on_q     <= 1'b0;
        end else begin
            frame_sel_q    <= frame_sel_d;
            read_address_q <= read_address_d;
            hit_q          <= hit_d;
            pixel_color_q  <= pixel_color_d;
            pixel_on_q     <= pixel_on_d;
        end
    end

    assign read_address = read_address_q;
    assign frame_sel    = frame_sel_q;
    assign pixel_color  = pixel_color_q;
    assign pixel_on     = pixel_on_q;

endmodule

// File: tb/tb_mario_sprite_seq_ctrl.sv
// Directed bench for mario_sprite_seq_ctrl: animation table, pixel vector table,
// streaming latency/mirroring sequence and asynchronous reset.
module tb_mario_sprite_seq_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic        walking = 1'b0;
    logic        airborne = 1'b0;
    logic        facing_left = 1'b0;
    logic [9:0]  DrawX = 10'd0;
    logic [9:0]  DrawY = 10'd0;
    logic [9:0]  mario_x = 10'd100;
    logic [9:0]  mario_y = 10'd200;
    logic [11:0] rom_drv = 12'd0;
    logic        rom_mode = 1'b0;
    logic [11:0] rom_color;
    logic [9:0]  read_address;
    logic [2:0]  frame_sel;
    logic [11:0] pixel_color;
    logic        pixel_on;

    int n_vec = 0;
    int n_err = 0;

    // ROM stand-in for streaming: colour is a function of address and never transparent
    assign rom_color = rom_mode ? (12'hA00 | {3'b000, read_address[8:0]}) : rom_drv;

    mario_sprite_seq_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .walking(walking),
        .airborne(airborne), .facing_left(facing_left), .DrawX(DrawX), .DrawY(DrawY),
        .mario_x(mario_x), .mario_y(mario_y), .rom_color(rom_color),
        .read_address(read_address), .frame_sel(frame_sel),
        .pixel_color(pixel_color), .pixel_on(pixel_on)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [9:0]  dx, dy, mx, my;
        logic        fl;
        logic [11:0] rom;
        logic [9:0]  e_addr;
        logic        e_on;
        logic [11:0] e_col;
    } pix_vec_t;

    typedef struct {
        logic       w, a;
        logic [2:0] e_sel;
    } anim_vec_t;

    pix_vec_t  pv[14];
    anim_vec_t av[$];

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input logic w, input logic a);
        walking    = w;
        airborne   = a;
        frame_tick = 1'b1;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        @(posedge Clk); #1;
    endtask

    function automatic logic [9:0] stream_addr(input int i);
        logic [9:0] x;
        x = 10'(1 + i);
        if (i >= 3) x = 10'd15 - x;
        return 10'd48 + x;
    endfunction

    task automatic drive_px(input int j);
        if (j < 6) begin
            DrawX       = 10'(101 + j);
            facing_left = (j >= 3);
        end else begin
            DrawX       = 10'd0;
            facing_left = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        pv[0]  = '{10'd103, 10'd205, 10'd100, 10'd200, 1'b0, 12'hF30, 10'd83,  1'b1, 12'hF30};
        pv[1]  = '{10'd103, 10'd205, 10'd100, 10'd200, 1'b1, 12'h808, 10'd92,  1'b0, 12'h808};
        pv[2]  = '{10'd99,  10'd205, 10'd100, 10'd200, 1'b0, 12'hF30, 10'd0,   1'b0, 12'h000};
        pv[3]  = '{10'd116, 10'd205, 10'd100, 10'd200, 1'b0, 12'hF30, 10'd0,   1'b0, 12'h000};
        pv[4]  = '{10'd115, 10'd231, 10'd100, 10'd200, 1'b0, 12'h0AB, 10'd511, 1'b1, 12'h0AB};
        pv[5]  = '{10'd100, 10'd200, 10'd100, 10'd200, 1'b0, 12'h123, 10'd0,   1'b1, 12'h123};
        pv[6]  = '{10'd100, 10'd200, 10'd100, 10'd200, 1'b1, 12'h808, 10'd15,  1'b0, 12'h808};
        pv[7]  = '{10'd108, 10'd232, 10'd100, 10'd200, 1'b0, 12'hF30, 10'd0,   1'b0, 12'h000};
        pv[8]  = '{10'd108, 10'd199, 10'd100, 10'd200, 1'b0, 12'hF30, 10'd0,   1'b0, 12'h000};
        pv[9]  = '{10'd5,   10'd205, 10'd630, 10'd200, 1'b0, 12'hF30, 10'd0,   1'b0, 12'h000};
        pv[10] = '{10'd639, 10'd205, 10'd630, 10'd200, 1'b1, 12'h0F0, 10'd86,  1'b1, 12'h0F0};
        pv[11] = '{10'd4,   10'd205, 10'd1020, 10'd200, 1'b0, 12'hF30, 10'd0,  1'b0, 12'h000};
        pv[12] = '{10'd107, 10'd3,   10'd100, 10'd1020, 1'b0, 12'hF30, 10'd0,  1'b0, 12'h000};
        pv[13] = '{10'd115, 10'd231, 10'd100, 10'd200, 1'b1, 12'hF30, 10'd496, 1'b1, 12'hF30};

        // Walk ticks 2..20: WALK2 at 7, WALK3 at 13, wrap to WALK1 at 19
        for (int k = 2; k <= 20; k++)
            av.push_back('{1'b1, 1'b0, (k < 7) ? 3'd1 : (k < 13) ? 3'd2 : (k < 19) ? 3'd3 : 3'd1});
        for (int k = 0; k < 4; k++) av.push_back('{1'b1, 1'b0, 3'd1});
        av.push_back('{1'b1, 1'b0, 3'd2});
        av.push_back('{1'b1, 1'b1, 3'd4});
        av.push_back('{1'b1, 1'b0, 3'd1});
        for (int k = 0; k < 5; k++) av.push_back('{1'b1, 1'b0, 3'd1});
        av.push_back('{1'b1, 1'b0, 3'd2});
        av.push_back('{1'b1, 1'b1, 3'd4});
        av.push_back('{1'b0, 1'b0, 3'd0});
        av.push_back('{1'b0, 1'b1, 3'd4});
        av.push_back('{1'b0, 1'b0, 3'd0});

        #3;
        chk("reset_read_address", {2'b00, read_address}, 12'd0);
        chk("reset_frame_sel", {9'd0, frame_sel}, 12'd0);
        chk("reset_pixel_color", pixel_color, 12'd0);
        chk("reset_pixel_on", {11'd0, pixel_on}, 12'd0);
        @(posedge Clk); @(posedge Clk); #1;
        Reset = 1'b0;

        // First walk tick: frame_sel must hold on the tick edge and change one cycle later
        walking    = 1'b1;
        frame_tick = 1'b1;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        chk("tick1_hold", {9'd0, frame_sel}, 12'd0);
        @(posedge Clk); #1;
        chk("tick1_walk1", {9'd0, frame_sel}, 12'd1);

        foreach (av[i]) begin
            tick(av[i].w, av[i].a);
            chk($sformatf("anim[%0d]", i), {9'd0, frame_sel}, {9'd0, av[i].e_sel});
        end

        foreach (pv[i]) begin
            DrawX = pv[i].dx; DrawY = pv[i].dy;
            mario_x = pv[i].mx; mario_y = pv[i].my;
            facing_left = pv[i].fl; rom_drv = pv[i].rom;
            @(posedge Clk); #1;
            chk($sformatf("pix[%0d].addr", i), {2'b00, read_address}, {2'b00, pv[i].e_addr});
            @(posedge Clk); #1;
            chk($sformatf("pix[%0d].on", i), {11'd0, pixel_on}, {11'd0, pv[i].e_on});
            chk($sformatf("pix[%0d].color", i), pixel_color, pv[i].e_col);
        end

        // Back-to-back pixels with facing_left flipping after the third one
        mario_x = 10'd100; mario_y = 10'd200; DrawY = 10'd203;
        rom_mode = 1'b1;
        drive_px(0);
        for (int k = 0; k < 8; k++) begin
            @(posedge Clk); #1;
            if (k < 6)
                chk($sformatf("stream_addr[%0d]", k), {2'b00, read_address}, {2'b00, stream_addr(k)});
            if (k >= 1 && k <= 6) begin
                chk($sformatf("stream_color[%0d]", k - 1), pixel_color,
                    12'hA00 | {2'b00, stream_addr(k - 1)});
                chk($sformatf("stream_on[%0d]", k - 1), {11'd0, pixel_on}, 12'd1);
            end
            drive_px(k + 1);
        end
        rom_mode = 1'b0;

        // Asynchronous reset in the middle of an opaque pixel while walking
        tick(1'b1, 1'b0);
        chk("pre_reset_frame_sel", {9'd0, frame_sel}, 12'd1);
        DrawX = 10'd103; DrawY = 10'd205; facing_left = 1'b0; rom_drv = 12'hF30;
        @(posedge Clk); @(posedge Clk); #1;
        chk("pre_reset_pixel_on", {11'd0, pixel_on}, 12'd1);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_read_address", {2'b00, read_address}, 12'd0);
        chk("async_frame_sel", {9'd0, frame_sel}, 12'd0);
        chk("async_pixel_color", pixel_color, 12'd0);
        chk("async_pixel_on", {11'd0, pixel_on}, 12'd0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        walking = 1'b0;
        @(posedge Clk); #1;
        chk("post_reset_stage1_addr", {2'b00, read_address}, 12'd83);
        chk("post_reset_stage1_on", {11'd0, pixel_on}, 12'd0);
        @(posedge Clk); #1;
        chk("post_reset_stage2_on", {11'd0, pixel_on}, 12'd1);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0);
            chk($sformatf("post_reset_stand[%0d]", k), {9'd0, frame_sel}, 12'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
